// File: rtl/xor16_arbiter_if.sv
// Requester/consumer bundle for xor16_arbiter: packed operands, one-hot grant,
// and a valid/ready result port. Master = issue sources + consumer, slave = arbiter.
interface xor16_arbiter_if #(
   parameter int NREQ = 4,
   parameter int W    = 16,
   parameter int IDW  = 3
);
   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] a_in;
   logic [NREQ*W-1:0] b_in;
   logic [NREQ-1:0]   gnt;
   logic [W-1:0]      out_data;
   logic [IDW-1:0]    out_id;
   logic              out_valid;
   logic              out_ready;
   logic              busy;

   modport master (
      output req, a_in, b_in, out_ready,
      input  gnt, out_data, out_id, out_valid, busy
   );

   modport slave (
      input  req, a_in, b_in, out_ready,
      output gnt, out_data, out_id, out_valid, busy
   );
endinterface

// File: rtl/xor16_arbiter.sv
// Round-robin arbiter sharing one W-bit XOR stage among NREQ requesters, with a
// one-entry registered result slot. Define XOR16_ARB_PRIO0_EN to give requester 0 absolute priority.
module xor16_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 16,
   parameter int IDW  = 3
) (
   input  logic           clk,
   input  logic           reset,
   xor16_arbiter_if.slave bus
);
   typedef enum logic {S_EMPTY, S_FULL} slot_e;

   slot_e             r_state;
   logic [IDW-1:0]    r_rr_ptr;
   logic [W-1:0]      r_data;
   logic [IDW-1:0]    r_id;

   logic              w_slot_free;
   logic              w_grant;
   logic              w_prio0;
   logic [2*NREQ-1:0] w_req2;
   logic [NREQ-1:0]   w_rot;
   logic [IDW-1:0]    w_off;
   logic [IDW:0]      w_sum;
   logic [IDW-1:0]    w_sel;
   logic [IDW-1:0]    w_ptr_nxt;
   logic [NREQ-1:0]   w_gnt;
   logic [W-1:0]      w_xor;

   assign w_slot_free = (r_state == S_EMPTY) || bus.out_ready;
   assign w_grant     = !reset && w_slot_free && (|bus.req);

   // Rotate requests so bit 0 is the requester at rr_ptr; the first set bit is the offset.
   assign w_req2 = {bus.req, bus.req};
   assign w_rot  = NREQ'(w_req2 >> r_rr_ptr);

   // NOTE: every combinational output gets a default first, so no path infers a latch.
   always_comb begin
      w_off = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (w_rot[k]) w_off = IDW'(k);
      end
   end

   assign w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};

   always_comb begin
      w_prio0 = 1'b0;
`ifdef XOR16_ARB_PRIO0_EN
      w_prio0 = bus.req[0];
`endif
      if (w_prio0)
         w_sel = '0;
      else if (w_sum >= (IDW+1)'(NREQ))
         w_sel = IDW'(w_sum - (IDW+1)'(NREQ));
      else
         w_sel = w_sum[IDW-1:0];
   end

   assign w_ptr_nxt = (w_sel == IDW'(NREQ - 1)) ? '0 : w_sel + 1'b1;
   assign w_gnt     = w_grant ? (NREQ'(1) << w_sel) : '0;

   always_comb begin
      w_xor = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_gnt[i]) w_xor = bus.a_in[i*W +: W] ^ bus.b_in[i*W +: W];
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_EMPTY;
         r_rr_ptr <= '0;
         r_data   <= '0;
         r_id     <= '0;
      end else if (w_grant) begin
         r_state <= S_FULL;
         r_data  <= w_xor;
         r_id    <= w_sel;
         if (!w_prio0) r_rr_ptr <= w_ptr_nxt;
      end else if (bus.out_ready) begin
         r_state <= S_EMPTY;
      end
   end

   assign bus.gnt       = w_gnt;
   assign bus.out_data  = r_data;
   assign bus.out_id    = r_id;
   assign bus.out_valid = (r_state == S_FULL);
   assign bus.busy      = (r_state == S_FULL) || (|bus.req);
endmodule

// File: tb/tb_xor16_arbiter.sv
// Self-checking bench for xor16_arbiter: directed scenarios with constant expectations,
// then randomized traffic against a behavioural model of the arbitration rules.
module tb_xor16_arbiter;
   localparam int NREQ = 4;
`ifdef XOR16_ARB_PRIO0_EN
   localparam bit PRIO = 1'b1;
`else
   localparam bit PRIO = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic [15:0] a_op [NREQ];
   logic [15:0] b_op [NREQ];
   int          vectors;
   int          miscompares;

   xor16_arbiter_if #(.NREQ(NREQ), .W(16), .IDW(3)) bus ();

   xor16_arbiter #(.NREQ(NREQ), .W(16), .IDW(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   assign bus.a_in = {a_op[3], a_op[2], a_op[1], a_op[0]};
   assign bus.b_in = {b_op[3], b_op[2], b_op[1], b_op[0]};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clk_step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      bus.req = '0;
      clk_step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.req = 4'b0001;
      clk_step();
      clk_step();
      @(negedge clk);
      vectors++; if (bus.gnt !== 4'b0000) begin miscompares++; $display("FAIL reset_gnt got=%b exp=0000", bus.gnt); end
      vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
      vectors++; if (bus.out_data !== 16'h0000) begin miscompares++; $display("FAIL reset_data got=%h exp=0000", bus.out_data); end
      vectors++; if (bus.out_id !== 3'd0) begin miscompares++; $display("FAIL reset_id got=%0d exp=0", bus.out_id); end
      vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL reset_busy_req got=%b exp=1", bus.busy); end
      bus.req = '0;
      #1;
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy_idle got=%b exp=0", bus.busy); end
      clk_step();
      reset = 1'b0;
   endtask

   task automatic test_basic();
      apply_reset();
      bus.out_ready = 1'b1;
      a_op[0] = 16'hFFFF; b_op[0] = 16'h0F0F;
      bus.req = 4'b0001;
      @(negedge clk);
      vectors++; if (bus.gnt !== 4'b0001) begin miscompares++; $display("FAIL basic_gnt got=%b exp=0001", bus.gnt); end
      vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_pre_valid got=%b exp=0", bus.out_valid); end
      clk_step();
      bus.req = '0;
      @(negedge clk);
      vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid got=%b exp=1", bus.out_valid); end
      vectors++; if (bus.out_data !== 16'hF0F0) begin miscompares++; $display("FAIL basic_data got=%h exp=f0f0", bus.out_data); end
      vectors++; if (bus.out_id !== 3'd0) begin miscompares++; $display("FAIL basic_id got=%0d exp=0", bus.out_id); end
      clk_step();
      @(negedge clk);
      vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_drain got=%b exp=0", bus.out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [3:0]  exp_gnt;
      logic [15:0] exp_data;
      apply_reset();
      bus.out_ready = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         a_op[i] = 16'(16'h1111 * (i + 1));
         b_op[i] = 16'h0000;
      end
      bus.req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         exp_gnt = 4'(1 << (k % 4));
         vectors++; if (bus.gnt !== exp_gnt) begin miscompares++; $display("FAIL b2b_gnt[%0d] got=%b exp=%b", k, bus.gnt, exp_gnt); end
         if (k > 0) begin
            exp_data = 16'(16'h1111 * ((k - 1) % 4 + 1));
            vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid[%0d] got=%b exp=1", k, bus.out_valid); end
            vectors++; if (bus.out_data !== exp_data) begin miscompares++; $display("FAIL b2b_data[%0d] got=%h exp=%h", k, bus.out_data, exp_data); end
            vectors++; if (bus.out_id !== 3'((k - 1) % 4)) begin miscompares++; $display("FAIL b2b_id[%0d] got=%0d exp=%0d", k, bus.out_id, (k - 1) % 4); end
         end
         clk_step();
      end
      bus.req = '0;
      @(negedge clk);
      vectors++; if (bus.out_data !== 16'h1111) begin miscompares++; $display("FAIL b2b_last_data got=%h exp=1111", bus.out_data); end
      clk_step();
   endtask

   task automatic test_backpressure();
      apply_reset();
      bus.out_ready = 1'b0;
      a_op[0] = 16'hAAAA; b_op[0] = 16'h0000;
      bus.req = 4'b0001;
      clk_step();
      a_op[2] = 16'h1234; b_op[2] = 16'hFF00;
      bus.req = 4'b0100;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         vectors++; if (bus.gnt !== 4'b0000) begin miscompares++; $display("FAIL bp_gnt[%0d] got=%b exp=0000", k, bus.gnt); end
         vectors++; if (bus.out_data !== 16'hAAAA) begin miscompares++; $display("FAIL bp_data[%0d] got=%h exp=aaaa", k, bus.out_data); end
         vectors++; if (bus.out_id !== 3'd0 || bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_id_valid[%0d] got=%0d/%b exp=0/1", k, bus.out_id, bus.out_valid); end
         clk_step();
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      vectors++; if (bus.gnt !== 4'b0100) begin miscompares++; $display("FAIL bp_release_gnt got=%b exp=0100", bus.gnt); end
      clk_step();
      bus.req = '0;
      @(negedge clk);
      vectors++; if (bus.out_data !== 16'hED34) begin miscompares++; $display("FAIL bp_new_data got=%h exp=ed34", bus.out_data); end
      vectors++; if (bus.out_id !== 3'd2) begin miscompares++; $display("FAIL bp_new_id got=%0d exp=2", bus.out_id); end
      clk_step();
   endtask

   task automatic test_wrap();
      apply_reset();
      bus.out_ready = 1'b1;
      bus.req = 4'b0100;
      @(negedge clk);
      vectors++; if (bus.gnt !== 4'b0100) begin miscompares++; $display("FAIL wrap_first got=%b exp=0100", bus.gnt); end
      clk_step();
      bus.req = 4'b1001;
      @(negedge clk);
      vectors++; if (bus.gnt !== 4'b1000) begin miscompares++; $display("FAIL wrap_gnt3 got=%b exp=1000", bus.gnt); end
      clk_step();
      bus.req = 4'b0001;
      @(negedge clk);
      vectors++; if (bus.gnt !== 4'b0001) begin miscompares++; $display("FAIL wrap_gnt0 got=%b exp=0001", bus.gnt); end
      clk_step();
      bus.req = '0;
      clk_step();
   endtask

   task automatic test_reset_midop();
      apply_reset();
      bus.out_ready = 1'b0;
      a_op[2] = 16'h5A5A; b_op[2] = 16'h0000;
      a_op[1] = 16'h0F0F; b_op[1] = 16'h00FF;
      bus.req = 4'b0100;
      clk_step();
      bus.req = 4'b1010;
      @(negedge clk);
      vectors++; if (bus.out_data !== 16'h5A5A || bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL mid_full got=%h/%b exp=5a5a/1", bus.out_data, bus.out_valid); end
      reset = 1'b1;
      clk_step();
      reset = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_valid got=%b exp=0", bus.out_valid); end
      vectors++; if (bus.out_data !== 16'h0000) begin miscompares++; $display("FAIL mid_data got=%h exp=0000", bus.out_data); end
      vectors++; if (bus.gnt !== 4'b0010) begin miscompares++; $display("FAIL mid_regrant got=%b exp=0010", bus.gnt); end
      clk_step();
      bus.req = 4'b1000;
      @(negedge clk);
      vectors++; if (bus.out_data !== 16'h0FF0 || bus.out_id !== 3'd1) begin miscompares++; $display("FAIL mid_result got=%h/%0d exp=0ff0/1", bus.out_data, bus.out_id); end
      vectors++; if (bus.gnt !== 4'b1000) begin miscompares++; $display("FAIL mid_next_gnt got=%b exp=1000", bus.gnt); end
      clk_step();
      bus.req = '0;
      clk_step();
   endtask

   task automatic test_prio();
      logic [3:0] exp_gnt;
      apply_reset();
      bus.out_ready = 1'b1;
      bus.req = 4'b0010;
      clk_step();
      bus.req = 4'b0101;
      exp_gnt = PRIO ? 4'b0001 : 4'b0100;
      @(negedge clk);
      vectors++; if (bus.gnt !== exp_gnt) begin miscompares++; $display("FAIL prio_gnt got=%b exp=%b", bus.gnt, exp_gnt); end
      clk_step();
      bus.req = 4'b0110;
      exp_gnt = PRIO ? 4'b0100 : 4'b0010;
      @(negedge clk);
      vectors++; if (bus.gnt !== exp_gnt) begin miscompares++; $display("FAIL prio_ptr_kept got=%b exp=%b", bus.gnt, exp_gnt); end
      clk_step();
      bus.req = '0;
      clk_step();
   endtask

   task automatic test_random();
      int          m_ptr;
      logic        m_valid;
      logic [15:0] m_data;
      int          m_id;
      int          sel;
      int          idx;
      logic [3:0]  r;
      logic [3:0]  exp_gnt;
      apply_reset();
      m_ptr = 0; m_valid = 1'b0; m_data = '0; m_id = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         r = 4'($urandom);
         bus.req = r;
         for (int i = 0; i < NREQ; i++) begin
            a_op[i] = 16'($urandom);
            b_op[i] = 16'($urandom);
         end
         bus.out_ready = ($urandom_range(0, 3) != 0);
         reset = ($urandom_range(0, 39) == 0);
         @(negedge clk);
         sel = -1;
         if (!reset && (!m_valid || bus.out_ready) && r != 4'b0000) begin
            if (PRIO && r[0]) sel = 0;
            for (int k = 0; k < NREQ; k++) begin
               idx = (m_ptr + k) % NREQ;
               if (sel < 0 && r[idx]) sel = idx;
            end
         end
         exp_gnt = (sel >= 0) ? 4'(1 << sel) : 4'b0000;
         vectors++; if (bus.gnt !== exp_gnt) begin miscompares++; $display("FAIL rnd_gnt[%0d] got=%b exp=%b", cyc, bus.gnt, exp_gnt); end
         vectors++; if (bus.out_valid !== m_valid) begin miscompares++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", cyc, bus.out_valid, m_valid); end
         vectors++; if (bus.busy !== (m_valid || r != 4'b0000)) begin miscompares++; $display("FAIL rnd_busy[%0d] got=%b exp=%b", cyc, bus.busy, (m_valid || r != 4'b0000)); end
         if (m_valid) begin
            vectors++; if (bus.out_data !== m_data || bus.out_id !== 3'(m_id)) begin miscompares++; $display("FAIL rnd_result[%0d] got=%h/%0d exp=%h/%0d", cyc, bus.out_data, bus.out_id, m_data, m_id); end
         end
         @(posedge clk);
         if (reset) begin
            m_valid = 1'b0; m_data = '0; m_id = 0; m_ptr = 0;
         end else if (sel >= 0) begin
            m_valid = 1'b1;
            m_data  = a_op[sel] ^ b_op[sel];
            m_id    = sel;
            if (!(PRIO && sel == 0)) m_ptr = (sel + 1) % NREQ;
         end else if (bus.out_ready) begin
            m_valid = 1'b0;
         end
         #1;
      end
      reset = 1'b0;
      bus.req = '0;
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      reset = 1'b1;
      bus.req = '0;
      bus.out_ready = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         a_op[i] = '0;
         b_op[i] = '0;
      end
      test_reset();
      test_basic();
      test_back_to_back();
      test_backpressure();
      test_wrap();
      test_reset_midop();
      test_prio();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
